// File: rtl/nco_pkg.sv
// Shared widths for the NCO and its downstream mixer/decimator.
package nco_pkg;
  localparam int NCO_W  = 5;
  localparam int PROD_W = 10;

  // Block sums reach at most D*256, which needs PROD_W + log2(D) signed bits.
  function automatic int acc_width(input int decim_log2);
    return PROD_W + decim_log2;
  endfunction
endpackage

// File: rtl/mix_accum.sv
// One mixer channel: registered (optionally negated) product, then integrate-and-dump.
module mix_accum
  import nco_pkg::*;
#(
  parameter int ACC_W = 14
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     neg_i,
  input  logic signed [NCO_W-1:0]  sample_i,
  input  logic signed [NCO_W-1:0]  coef_i,
  input  logic                     acc_en_i,
  input  logic                     dump_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [PROD_W-1:0] s_ext;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] mult;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  // 5x5 signed products span -256..+256, so a 10-bit result is exact, negated or not.
  assign s_ext    = {{(PROD_W-NCO_W){sample_i[NCO_W-1]}}, sample_i};
  assign c_ext    = {{(PROD_W-NCO_W){coef_i[NCO_W-1]}}, coef_i};
  assign mult     = s_ext * c_ext;
  assign prod_d   = neg_i ? -mult : mult;
  assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign sum_o    = acc_q + prod_ext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else if (clk_en) begin
      prod_q <= prod_d;
      if (acc_en_i) acc_q <= dump_i ? '0 : sum_o;
    end
  end

endmodule

// File: rtl/iq_mixer_decim.sv
// Quadrature mixer with integrate-and-dump decimation by 2^DECIM_LOG2 and a valid/ready output register.
module iq_mixer_decim
  import nco_pkg::*;
#(
  parameter int DECIM_LOG2   = 4,
  parameter int SAMPLE_DELAY = 3,
  parameter int ACC_W        = acc_width(DECIM_LOG2)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic signed [NCO_W-1:0]  sample_in,
  input  logic signed [NCO_W-1:0]  sine_bits,
  input  logic signed [NCO_W-1:0]  cosine_bits,
  output logic signed [ACC_W-1:0]  i_out,
  output logic signed [ACC_W-1:0]  q_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  logic signed [NCO_W-1:0]  s_dly;
  logic signed [NCO_W-1:0]  s_q, sin_q, cos_q;
  logic [1:0]               fill_q;
  logic [DECIM_LOG2-1:0]    cnt_q;
  logic                     acc_en, dump;
  logic signed [ACC_W-1:0]  sum_i, sum_q;
  logic signed [ACC_W-1:0]  i_d, i_q, q_d, q_q;
  logic                     valid_d, valid_q, ovr_d, ovr_q;

  // Delay line aligning the sample with the NCO's output latency.
  if (SAMPLE_DELAY == 0) begin : g_no_dly
    assign s_dly = sample_in;
  end else begin : g_dly
    logic [NCO_W-1:0] dly_q [SAMPLE_DELAY];
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < SAMPLE_DELAY; k++) dly_q[k] <= '0;
      end else if (clk_en) begin
        dly_q[0] <= sample_in;
        for (int k = 1; k < SAMPLE_DELAY; k++) dly_q[k] <= dly_q[k-1];
      end
    end
    assign s_dly = dly_q[SAMPLE_DELAY-1];
  end

  // Accumulation starts only once stage 1 and stage 2 both hold real data.
  assign acc_en = clk_en && (fill_q == 2'd2);
  assign dump   = acc_en && (cnt_q == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      sin_q  <= '0;
      cos_q  <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else if (clk_en) begin
      s_q   <= s_dly;
      sin_q <= sine_bits;
      cos_q <= cosine_bits;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      if (acc_en) cnt_q <= cnt_q + 1'b1;
    end
  end

  mix_accum #(.ACC_W(ACC_W)) u_i (
    .clock(clock), .reset(reset), .clk_en(clk_en), .neg_i(1'b0),
    .sample_i(s_q), .coef_i(cos_q), .acc_en_i(acc_en), .dump_i(dump), .sum_o(sum_i)
  );

  mix_accum #(.ACC_W(ACC_W)) u_q (
    .clock(clock), .reset(reset), .clk_en(clk_en), .neg_i(1'b1),
    .sample_i(s_q), .coef_i(sin_q), .acc_en_i(acc_en), .dump_i(dump), .sum_o(sum_q)
  );

  // Handshake: out_valid && out_ready accepts; a dump always loads and keeps valid high,
  // flagging overrun only when the held block was still unaccepted.
  always_comb begin
    i_d     = i_q;
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (dump) begin
      i_d     = sum_i;
      q_d     = sum_q;
      valid_d = 1'b1;
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_iq_mixer_decim.sv
// Bench for iq_mixer_decim (D=16, no sample delay): queue-based block-sum model plus literal pins.
module tb_iq_mixer_decim;
  localparam int L  = 4;
  localparam int D  = 16;
  localparam int AW = 14;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic out_ready = 1'b0;
  logic signed [4:0] sample_in = '0;
  logic signed [4:0] sine_bits = '0;
  logic signed [4:0] cosine_bits = '0;
  logic signed [AW-1:0] i_out, q_out;
  logic out_valid, overrun;

  int total = 0;
  int bad = 0;

  int mode = 0;
  int phase = 0;
  logic rst_cmd = 1'b1;
  logic signed [4:0] s_cfg = '0, sin_cfg = '0, cos_cfg = '0;
  logic rdy_cfg = 1'b1;

  iq_mixer_decim #(.DECIM_LOG2(L), .SAMPLE_DELAY(0)) dut (
    .clock(clock), .reset(reset), .clk_en(clk_en),
    .sample_in(sample_in), .sine_bits(sine_bits), .cosine_bits(cosine_bits),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  // clock
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, results are read 1 time unit after the rising edge
  task automatic step();
    @(negedge clock);
    reset = rst_cmd;
    case (mode)
      0: clk_en = 1'b1;
      1: clk_en = (phase % 3 == 0);
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
    phase++;
    if (mode == 2) begin
      sample_in   = 5'($urandom_range(0, 31));
      sine_bits   = 5'($urandom_range(0, 31));
      cosine_bits = 5'($urandom_range(0, 31));
      out_ready   = ($urandom_range(0, 3) != 0);
    end else begin
      sample_in   = s_cfg;
      sine_bits   = sin_cfg;
      cosine_bits = cos_cfg;
      out_ready   = rdy_cfg;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 300);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected out_valid", n);
    end
  endtask

  // behavioural model: products in enabled order; the first two after reset are pipeline fill
  int pi_q[$], pq_q[$];
  int bsum_i = 0, bsum_q = 0, bn = 0;
  int exp_i = 0, exp_q = 0;
  bit exp_v = 0, exp_o = 0;

  always @(posedge clock) begin
    bit accept;
    bit dumped;
    if (reset) begin
      pi_q.delete(); pq_q.delete();
      bsum_i = 0; bsum_q = 0; bn = 0;
      exp_i = 0; exp_q = 0; exp_v = 0; exp_o = 0;
    end else begin
      accept = exp_v && out_ready;
      dumped = 0;
      if (clk_en) begin
        pi_q.push_back(int'(sample_in) * int'(cosine_bits));
        pq_q.push_back(-(int'(sample_in) * int'(sine_bits)));
        if (pi_q.size() > 2) begin
          bsum_i += pi_q.pop_front();
          bsum_q += pq_q.pop_front();
          bn++;
          if (bn == D) begin
            dumped = 1;
            exp_i = bsum_i; exp_q = bsum_q;
            bsum_i = 0; bsum_q = 0; bn = 0;
          end
        end
      end
      if (dumped) begin
        if (exp_v && !out_ready) exp_o = 1;
        exp_v = 1;
      end else if (accept) begin
        exp_v = 0;
      end
    end
  end

  // compare process: every cycle
  always @(posedge clock) begin
    #1;
    check("m_valid", int'(out_valid), int'(exp_v));
    check("m_overrun", int'(overrun), int'(exp_o));
    check("m_i", int'(i_out), exp_i);
    check("m_q", int'(q_out), exp_q);
  end

  task automatic do_reset();
    rst_cmd = 1'b1;
    repeat (2) step();
    rst_cmd = 1'b0;
  endtask

  initial begin
    int n;
    rst_cmd = 1'b1;
    repeat (3) step();
    check("rst_i", int'(i_out), 0);
    check("rst_q", int'(q_out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);

    // constant tone: 15*15*16
    s_cfg = 5'sd15; cos_cfg = 5'sd15; sin_cfg = 5'sd0; rdy_cfg = 1'b1;
    rst_cmd = 1'b0;
    wait_valid(n);
    check("t1_latency", n, 18);
    check("t1_i", int'(i_out), 3600);
    check("t1_q", int'(q_out), 0);
    wait_valid(n);
    check("t1_spacing", n, D);

    // full-scale negative corner
    s_cfg = -5'sd16; cos_cfg = -5'sd16; sin_cfg = -5'sd16;
    repeat (3) wait_valid(n);
    check("t2_i", int'(i_out), 4096);
    check("t2_q", int'(q_out), -4096);

    // clk_en 1,0,0 pattern
    s_cfg = 5'sd15; cos_cfg = 5'sd15; sin_cfg = 5'sd0;
    repeat (2) wait_valid(n);
    mode = 1; phase = 0;
    repeat (2) wait_valid(n);
    wait_valid(n);
    check("t3_spacing", n, 48);
    check("t3_i", int'(i_out), 3600);
    check("t3_q", int'(q_out), 0);
    mode = 0;

    // overrun with consumer stalled
    do_reset();
    rdy_cfg = 1'b0;
    wait_valid(n);
    repeat (D) step();
    check("t4_overrun", int'(overrun), 1);
    check("t4_valid", int'(out_valid), 1);
    check("t4_i", int'(i_out), 3600);
    repeat (D) step();
    check("t4_sticky", int'(overrun), 1);
    rdy_cfg = 1'b1;
    step();
    check("t4_accept_valid", int'(out_valid), 0);
    check("t4_accept_overrun", int'(overrun), 1);

    // reset mid-block discards the partial sum
    do_reset();
    s_cfg = 5'sd7; cos_cfg = 5'sd3; sin_cfg = 5'sd5;
    repeat (9) step();
    rst_cmd = 1'b1;
    s_cfg = 5'sd15; cos_cfg = 5'sd15; sin_cfg = 5'sd0;
    step();
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_overrun", int'(overrun), 0);
    step();
    rst_cmd = 1'b0;
    wait_valid(n);
    check("t5_latency", n, 18);
    check("t5_i", int'(i_out), 3600);

    // dump coinciding with accept
    do_reset();
    rdy_cfg = 1'b0;
    wait_valid(n);
    repeat (D - 1) step();
    rdy_cfg = 1'b1;
    step();
    check("t6_valid", int'(out_valid), 1);
    check("t6_overrun", int'(overrun), 0);
    check("t6_i", int'(i_out), 3600);
    step();
    check("t6_cleared", int'(out_valid), 0);

    // randomized stimulus against the model
    do_reset();
    mode = 2;
    repeat (3000) step();
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
